// File: rtl/data_req_issue.sv
// MEM-stage data request issuer: aligns store data/strobes, runs the
// req/addr_ok/data_ok bus handshake and holds the raw load word for WB.
`timescale 1ns/1ps
module data_req_issue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_EX_MEM,
    input  logic                  MemWrite_EX_MEM,
    input  logic                  SB_EX_MEM,
    input  logic                  SH_EX_MEM,
    input  logic                  SWL_EX_MEM,
    input  logic                  SWR_EX_MEM,
    input  logic [ADDR_W-1:0]     Addr_EX_MEM,
    input  logic [DATA_W-1:0]     RtData_EX_MEM,
    output logic                  mem_allowin,
    input  logic                  wb_allowin,
    output logic                  mem_done,
    output logic [DATA_W-1:0]     MemRdata_MEM,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W/8-1:0]   data_wstrb,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          state;
    logic [1:0]          ofs;
    logic [ADDR_W-1:0]   addr_al;
    logic [DATA_W-1:0]   rt;
    logic                n_wr;
    logic [1:0]          n_size;
    logic [ADDR_W-1:0]   n_addr;
    logic [DATA_W-1:0]   n_wdata;
    logic [DATA_W/8-1:0] n_wstrb;
    logic                accept;

    assign ofs     = Addr_EX_MEM[1:0];
    assign addr_al = {Addr_EX_MEM[ADDR_W-1:2], 2'b00};
    assign rt      = RtData_EX_MEM;

    assign mem_done    = (state == DONE);
    assign mem_allowin = (state == IDLE) | ((state == DONE) & wb_allowin);
    assign accept      = valid_EX_MEM & mem_allowin;

    // Store-flag priority: SWL > SWR > SH > SB > SW
    always_comb begin
        n_wr    = MemWrite_EX_MEM;
        n_size  = 2'd2;
        n_addr  = Addr_EX_MEM;
        n_wdata = rt;
        n_wstrb = 4'b1111;
        if (!MemWrite_EX_MEM) begin
            n_addr  = addr_al;
            n_wdata = '0;
            n_wstrb = 4'b0000;
        end else if (SWL_EX_MEM) begin
            n_addr = addr_al;
            unique case (ofs)
                2'd0: begin n_wstrb = 4'b0001; n_wdata = {24'b0, rt[31:24]}; end
                2'd1: begin n_wstrb = 4'b0011; n_wdata = {16'b0, rt[31:16]}; end
                2'd2: begin n_wstrb = 4'b0111; n_wdata = {8'b0, rt[31:8]}; end
                default: begin n_wstrb = 4'b1111; n_wdata = rt; end
            endcase
        end else if (SWR_EX_MEM) begin
            n_addr = addr_al;
            unique case (ofs)
                2'd0: begin n_wstrb = 4'b1111; n_wdata = rt; end
                2'd1: begin n_wstrb = 4'b1110; n_wdata = {rt[23:0], 8'b0}; end
                2'd2: begin n_wstrb = 4'b1100; n_wdata = {rt[15:0], 16'b0}; end
                default: begin n_wstrb = 4'b1000; n_wdata = {rt[7:0], 24'b0}; end
            endcase
        end else if (SH_EX_MEM) begin
            n_size  = 2'd1;
            n_wdata = {2{rt[15:0]}};
            n_wstrb = ofs[1] ? 4'b1100 : 4'b0011;
        end else if (SB_EX_MEM) begin
            n_size  = 2'd0;
            n_wdata = {4{rt[7:0]}};
            n_wstrb = 4'b0001 << ofs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            data_req     <= 1'b0;
            data_wr      <= 1'b0;
            data_size    <= 2'd0;
            data_addr    <= '0;
            data_wdata   <= '0;
            data_wstrb   <= '0;
            MemRdata_MEM <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= REQ;
                        data_req   <= 1'b1;
                        data_wr    <= n_wr;
                        data_size  <= n_size;
                        data_addr  <= n_addr;
                        data_wdata <= n_wdata;
                        data_wstrb <= n_wstrb;
                    end else if (state == DONE && wb_allowin) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                default: begin
                    if (data_data_ok) begin
                        if (!data_wr)
                            MemRdata_MEM <= data_rdata;
                        state <= DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_req_issue.sv
// Scoreboard bench for data_req_issue: random ops, random slave timing,
// spurious data_ok, and a reset abandoning an op in WAIT.
`timescale 1ns/1ps
module tb_data_req_issue;

    typedef struct {
        bit          wr, sb, sh, swl, swr;
        logic [31:0] addr, rt;
    } op_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 0, rst = 1;
    logic        valid_EX_MEM = 0, MemWrite_EX_MEM = 0;
    logic        SB_EX_MEM = 0, SH_EX_MEM = 0, SWL_EX_MEM = 0, SWR_EX_MEM = 0;
    logic [31:0] Addr_EX_MEM = 0, RtData_EX_MEM = 0;
    logic        mem_allowin, wb_allowin = 1, mem_done;
    logic [31:0] MemRdata_MEM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 0, data_data_ok = 0;
    logic [31:0] data_rdata = 0;

    data_req_issue dut (
        .clk(clk), .rst(rst),
        .valid_EX_MEM(valid_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
        .SB_EX_MEM(SB_EX_MEM), .SH_EX_MEM(SH_EX_MEM),
        .SWL_EX_MEM(SWL_EX_MEM), .SWR_EX_MEM(SWR_EX_MEM),
        .Addr_EX_MEM(Addr_EX_MEM), .RtData_EX_MEM(RtData_EX_MEM),
        .mem_allowin(mem_allowin), .wb_allowin(wb_allowin),
        .mem_done(mem_done), .MemRdata_MEM(MemRdata_MEM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    int   n_pass = 0, n_total = 0, consumed = 0;
    bit   stop = 0;
    op_t  ops[$];
    req_t req_q[$];
    logic [31:0] res_q[$];
    logic [31:0] last_load = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: byte lanes derived from shift arithmetic on the offset
    function automatic req_t model(op_t o);
        req_t r;
        int a;
        a = int'(o.addr[1:0]);
        r.wr = o.wr;
        r.size = 2'd2;
        r.addr = o.addr;
        r.wdata = o.rt;
        r.wstrb = 4'hF;
        if (!o.wr) begin
            r.addr = o.addr & ~32'd3;
            r.wstrb = 4'h0;
        end else if (o.swl) begin
            r.addr = o.addr & ~32'd3;
            r.wdata = o.rt >> (8 * (3 - a));
            r.wstrb = 4'((1 << (a + 1)) - 1);
        end else if (o.swr) begin
            r.addr = o.addr & ~32'd3;
            r.wdata = o.rt << (8 * a);
            r.wstrb = 4'((15 << a) & 15);
        end else if (o.sh) begin
            r.size = 2'd1;
            r.wdata = {o.rt[15:0], o.rt[15:0]};
            r.wstrb = (a >= 2) ? 4'hC : 4'h3;
        end else if (o.sb) begin
            r.size = 2'd0;
            r.wdata = {4{o.rt[7:0]}};
            r.wstrb = 4'(1 << a);
        end
        return r;
    endfunction

    function automatic op_t mk(bit wr, bit sb, bit sh, bit swl, bit swr,
                               logic [31:0] addr, logic [31:0] rt);
        op_t o;
        o.wr = wr; o.sb = sb; o.sh = sh; o.swl = swl; o.swr = swr;
        o.addr = addr; o.rt = rt;
        return o;
    endfunction

    task automatic present(op_t o);
        valid_EX_MEM = 1;
        MemWrite_EX_MEM = o.wr;
        SB_EX_MEM = o.sb; SH_EX_MEM = o.sh;
        SWL_EX_MEM = o.swl; SWR_EX_MEM = o.swr;
        Addr_EX_MEM = o.addr; RtData_EX_MEM = o.rt;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && data_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(data_req), 32'd0);
                end else begin
                    chk("req_wr", 32'(data_wr), 32'(req_q[0].wr));
                    chk("req_size", 32'(data_size), 32'(req_q[0].size));
                    chk("req_addr", data_addr, req_q[0].addr);
                    chk("req_wstrb", 32'(data_wstrb), 32'(req_q[0].wstrb));
                    if (req_q[0].wr)
                        chk("req_wdata", data_wdata, req_q[0].wdata);
                    if (data_addr_ok) void'(req_q.pop_front());
                end
            end
            if (!rst && mem_done) begin
                chk("allowin_in_done", 32'(mem_allowin), 32'(wb_allowin));
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'(mem_done), 32'd0);
                end else begin
                    chk("rdata", MemRdata_MEM, res_q[0]);
                    if (wb_allowin) begin
                        void'(res_q.pop_front());
                        consumed++;
                    end
                end
            end
        end
    endtask

    task automatic driver();
        bit acc;
        foreach (ops[k]) begin
            present(ops[k]);
            acc = 0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk);
                acc = mem_allowin;
                @(posedge clk);
                #1;
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
            req_q.push_back(model(ops[k]));
            valid_EX_MEM = 0;
            @(negedge clk);
            chk("issue_latency", 32'(data_req), 32'd1);
            repeat ($urandom % 3) @(posedge clk);
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (consumed == ops.size() && req_q.size() == 0) break;
        end
        chk("drain_count", 32'(consumed), 32'(ops.size()));
        stop = 1;
    endtask

    task automatic slave();
        bit pending = 0, pwr = 0, expd = 0, hs, hs_wr, dk;
        int dly = 0;
        while (!stop) begin
            @(negedge clk);
            if (expd) chk("done_after_data_ok", 32'(mem_done), 32'd1);
            hs = data_req & data_addr_ok;
            hs_wr = data_wr;
            dk = data_data_ok & pending;
            @(posedge clk);
            #1;
            expd = dk;
            if (dk) pending = 0;
            if (hs) begin
                pending = 1;
                pwr = hs_wr;
                dly = $urandom % 3;
            end
            wb_allowin = ($urandom % 4) != 0;
            data_addr_ok = ($urandom % 3) != 0;
            data_rdata = $urandom;
            if (pending) begin
                if (dly == 0) begin
                    data_data_ok = 1;
                    if (!pwr) last_load = data_rdata;
                    res_q.push_back(last_load);
                end else begin
                    dly--;
                    data_data_ok = 0;
                end
            end else begin
                data_data_ok = ($urandom % 4) == 0;
            end
        end
    endtask

    initial begin
        ops.push_back(mk(1, 0, 0, 0, 0, 32'h1000, 32'hA1B2C3D4));
        for (int i = 0; i < 4; i++)
            ops.push_back(mk(1, 1, 0, 0, 0, 32'h4000 + i, 32'h000000EF));
        ops.push_back(mk(1, 0, 0, 1, 0, 32'h5001, 32'h11223344));
        ops.push_back(mk(1, 0, 0, 0, 1, 32'h5001, 32'h11223344));
        ops.push_back(mk(0, 0, 0, 0, 0, 32'h2003, 32'h0));
        ops.push_back(mk(1, 1, 1, 1, 1, 32'h6002, 32'hCAFEF00D));
        for (int i = 0; i < 60; i++) begin
            int kind;
            op_t o;
            kind = $urandom % 6;
            o = mk(kind != 0, kind == 3, kind == 2, kind == 4, kind == 5,
                   $urandom, $urandom);
            if (kind != 0 && ($urandom % 6) == 0) begin
                o.sb = $urandom; o.sh = $urandom;
                o.swl = $urandom; o.swr = $urandom;
            end
            ops.push_back(o);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", 32'(mem_allowin), 32'd1);
        chk("rst_done", 32'(mem_done), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_rdata", MemRdata_MEM, 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        @(posedge clk);
        #1 rst = 0;

        fork
            monitor();
        join_none
        fork
            driver();
            slave();
        join

        @(posedge clk);
        #1;
        wb_allowin = 1;
        data_addr_ok = 0;
        data_data_ok = 0;
        present(mk(0, 0, 0, 0, 0, 32'h3001, 32'h0));
        req_q.push_back(model(mk(0, 0, 0, 0, 0, 32'h3001, 32'h0)));
        @(posedge clk);
        #1 valid_EX_MEM = 0;
        data_addr_ok = 1;
        @(posedge clk);
        #1 data_addr_ok = 0;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        data_data_ok = 1;
        data_rdata = 32'h55AA55AA;
        @(posedge clk);
        #1 data_data_ok = 0;
        @(negedge clk);
        chk("midrst_done", 32'(mem_done), 32'd0);
        chk("midrst_rdata", MemRdata_MEM, 32'd0);
        chk("midrst_allowin", 32'(mem_allowin), 32'd1);
        chk("midrst_req", 32'(data_req), 32'd0);
        chk("midrst_reqq", 32'(req_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
